// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, alternates fetch/data memory slots,
// applies EX-stage redirects with younger-stage kills, and drains the pipe on halt.
module pc_fetch_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              DRAIN_SLOTS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch_sel,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic            mem_sel,
  output logic            fetch_valid,
  output logic            adv,
  output logic            kill_ifid,
  output logic            kill_idex,
  output logic            misaligned,
  output logic            halted
);

  localparam int CW = $clog2(DRAIN_SLOTS + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t          state, state_n;
  logic            ph;
  logic [CW-1:0]   cnt, cnt_n;
  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] target;
  logic            mis_n;

  assign mem_sel     = !ph && (state != S_HALTED);
  assign fetch_valid = mem_sel && (state == S_RUN);
  assign adv         = ph && (state != S_HALTED);
  assign halted      = (state == S_HALTED);
  assign target      = jump ? jump_target : branch_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      ph         <= 1'b0;
      cnt        <= '0;
      pc         <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      state      <= state_n;
      ph         <= (state == S_HALTED) ? ph : ~ph;
      cnt        <= cnt_n;
      pc         <= pc_n;
      misaligned <= mis_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pc_n      = pc;
    mis_n     = misaligned;
    kill_ifid = 1'b0;
    kill_idex = 1'b0;
    if (adv) begin
      unique case (state)
        S_RUN: begin
          // Redirect wins over both stall and halt.
          if (jump || branch_sel) begin
            pc_n      = {target[XLEN-1:2], 2'b00};
            kill_ifid = 1'b1;
            kill_idex = 1'b1;
            if (target[1:0] != 2'b00) mis_n = 1'b1;
          end else if (!stall) begin
            if (halt) begin
              state_n   = S_DRAIN;
              cnt_n     = CW'(DRAIN_SLOTS);
              kill_ifid = 1'b1;
            end else begin
              pc_n = pc + XLEN'(4);
            end
          end
        end
        S_DRAIN: begin
          kill_ifid = 1'b1;
          cnt_n     = cnt - CW'(1);
          if (cnt == CW'(1)) state_n = S_HALTED;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed test-plan scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_pc_fetch_ctrl;

  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_sel, jump, stall, halt;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc;
  logic        mem_sel, fetch_valid, adv, kill_ifid, kill_idex, misaligned, halted;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000), .DRAIN_SLOTS(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .branch_sel(branch_sel), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .stall(stall), .halt(halt),
    .pc(pc), .mem_sel(mem_sel), .fetch_valid(fetch_valid), .adv(adv),
    .kill_ifid(kill_ifid), .kill_idex(kill_idex),
    .misaligned(misaligned), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: slot parity, drain countdown, stopped flag.
  logic [31:0] m_pc;
  bit          m_slot_data, m_draining, m_stopped, m_mis;
  int          m_left;

  always @(negedge clk) begin
    bit e_msel, e_adv, running, taken, e_kif;
    logic [31:0] tgt;
    if (!rst_n) begin
      m_pc = 32'h0; m_slot_data = 0; m_draining = 0; m_stopped = 0; m_mis = 0; m_left = 0;
    end else begin
      running = !m_draining && !m_stopped;
      e_msel  = !m_slot_data && !m_stopped;
      e_adv   = m_slot_data && !m_stopped;
      taken   = e_adv && running && (jump || branch_sel);
      tgt     = jump ? jump_target : branch_target;
      e_kif   = taken || (e_adv && running && halt && !stall) || (e_adv && m_draining);
      chk("m_pc", pc, m_pc);
      chk("m_mem_sel", 32'(mem_sel), 32'(e_msel));
      chk("m_fetch_valid", 32'(fetch_valid), 32'(e_msel && running));
      chk("m_adv", 32'(adv), 32'(e_adv));
      chk("m_misaligned", 32'(misaligned), 32'(m_mis));
      chk("m_halted", 32'(halted), 32'(m_stopped));
      if (e_adv) begin
        chk("m_kill_ifid", 32'(kill_ifid), 32'(e_kif));
        chk("m_kill_idex", 32'(kill_idex), 32'(taken));
      end
      if (!m_stopped) m_slot_data = !m_slot_data;
      if (e_adv) begin
        if (taken) begin
          m_pc = tgt - (tgt % 4);
          if (tgt % 4 != 0) m_mis = 1;
        end else if (running) begin
          if (halt && !stall) begin
            m_draining = 1; m_left = DRAIN;
          end else if (!stall) begin
            m_pc = m_pc + 32'd4;
          end
        end else if (m_draining) begin
          m_left--;
          if (m_left == 0) begin m_draining = 0; m_stopped = 1; end
        end
      end
    end
  end

  task automatic idle();
    branch_sel = 0; jump = 0; stall = 0; halt = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Advance until the current cycle is an adv cycle with the given pc.
  task automatic run_to(input logic [31:0] t);
    int n = 0;
    while (!(pc == t && adv) && n < 200) begin step(); n++; end
    if (n >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL run_to: pc %h never reached adv, want %h", pc, t);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; idle(); step(); rst_n = 1;
  endtask

  initial begin
    logic [31:0] seq_pc [8];
    int advs;
    seq_pc = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd8, 32'd8, 32'd12, 32'd12};
    rst_n = 0; idle();
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_mem_sel", 32'(mem_sel), 32'd1);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd1);
    chk("rst_adv", 32'(adv), 32'd0);
    chk("rst_kills", {30'd0, kill_ifid, kill_idex}, 32'd0);
    chk("rst_mis_halt", {30'd0, misaligned, halted}, 32'd0);
    step(); step(); rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("seq_pc", pc, seq_pc[i]);
      chk("seq_mem_sel", 32'(mem_sel), 32'(i % 2 == 0));
      chk("seq_adv", 32'(adv), 32'(i % 2 == 1));
      step();
    end

    do_reset();
    run_to(32'h8);
    branch_sel = 1; branch_target = 32'h40;
    @(negedge clk);
    chk("br_kills", {30'd0, kill_ifid, kill_idex}, 32'd3);
    step(); idle();
    chk("br_pc", pc, 32'h40);
    run_to(32'h40);
    @(negedge clk);
    chk("nobr_kills", {30'd0, kill_ifid, kill_idex}, 32'd0);
    step();
    chk("br_pc_next", pc, 32'h44);

    run_to(32'h44);
    jump = 1; jump_target = 32'h102; branch_sel = 1; branch_target = 32'h200; stall = 1;
    step(); idle();
    chk("prio_pc", pc, 32'h100);
    chk("prio_mis", 32'(misaligned), 32'd1);
    run_to(32'h100);
    jump = 1; jump_target = 32'h10;
    step(); idle();
    chk("aligned_pc", pc, 32'h10);
    chk("mis_sticky", 32'(misaligned), 32'd1);

    for (int k = 0; k < 2; k++) begin
      run_to(32'h10);
      stall = 1;
      @(negedge clk);
      chk("stall_kills", {30'd0, kill_ifid, kill_idex}, 32'd0);
      step(); idle();
      chk("stall_pc", pc, 32'h10);
    end
    run_to(32'h10);
    step();
    chk("unstall_pc", pc, 32'h14);

    run_to(32'h20);
    halt = 1;
    @(negedge clk);
    chk("halt_kills", {30'd0, kill_ifid, kill_idex}, 32'd2);
    step();
    branch_sel = 1; branch_target = 32'h300;
    advs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (halted) break;
      chk("drain_fv", 32'(fetch_valid), 32'd0);
      if (adv) begin
        advs++;
        chk("drain_kill_ifid", 32'(kill_ifid), 32'd1);
      end
      step();
    end
    idle();
    chk("drain_advs", 32'(advs), 32'(DRAIN));
    chk("halted", 32'(halted), 32'd1);
    chk("halted_adv_msel", {30'd0, adv, mem_sel}, 32'd0);
    chk("halted_pc", pc, 32'h20);

    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_flags", {26'd0, mem_sel, fetch_valid, adv, misaligned, halted, kill_ifid}, 32'h30);
    step(); rst_n = 1;

    run_to(32'h0);
    jump = 1; jump_target = 32'hFFFF_FFFC;
    step(); idle();
    chk("wrap_top", pc, 32'hFFFF_FFFC);
    run_to(32'hFFFF_FFFC);
    step();
    chk("wrap_zero", pc, 32'h0);

    for (int c = 0; c < 4000; c++) begin
      if (halted || $urandom_range(0, 799) == 0) begin
        do_reset();
        continue;
      end
      branch_sel    = ($urandom_range(0, 3) == 0);
      jump          = ($urandom_range(0, 5) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      halt          = ($urandom_range(0, 39) == 0);
      branch_target = $urandom;
      jump_target   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : $urandom;
      if ($urandom_range(0, 7) != 0) begin
        branch_target[1:0] = 2'b00;
        jump_target[1:0]   = 2'b00;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage controller for the single-memory pipelined RV32 core. It holds the program counter and generates the two-cycle memory phase that shares the unified memory between instruction fetch and data access. It consumes the EX-stage redirect (`branch_sel` from the branch decision logic, plus jump requests), redirects the PC and kills younger pipeline stages. It also sequences an orderly halt (drain, then stop) on ECALL/EBREAK.

## Interface
Parameters:
- `XLEN`, 32, datapath/PC width
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `DRAIN_SLOTS`, 3, pipeline advances allowed after halt entry before stopping (≥1)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `branch_sel`  in  1  conditional branch taken (EX stage)
- `branch_target`  in  XLEN  branch target PC (EX stage)
- `jump`  in  1  JAL/JALR in EX
- `jump_target`  in  XLEN  jump target PC
- `stall`  in  1  load-use stall from hazard unit
- `halt`  in  1  ECALL/EBREAK decoded in ID
- `pc`  out  XLEN  current fetch PC
- `mem_sel`  out  1  1 = instruction slot, 0 = data slot
- `fetch_valid`  out  1  instruction read issued this cycle
- `adv`  out  1  pipeline-register enable pulse
- `kill_ifid`  out  1  load NOP into IF/ID on this adv
- `kill_idex`  out  1  load NOP into ID/EX on this adv
- `misaligned`  out  1  sticky: a redirect target had bits [1:0] ≠ 0
- `halted`  out  1  core stopped

## Operation
- Phase register `ph`: 0 = fetch slot, 1 = data slot. Toggles every cycle except in HALTED, where it is frozen.
- `mem_sel = (ph==0) && state!=HALTED`. `fetch_valid = mem_sel && state==RUN`.
- `adv = (ph==1) && state!=HALTED`. All PC/state updates happen only on adv cycles.
- `redirect = adv && state==RUN && (jump || branch_sel)`. The target is `jump_target` if `jump`, otherwise `branch_target` (jump has priority).
- On redirect:
  - `pc <= target & ~3`.
  - `kill_ifid = kill_idex = 1`, combinational in the same cycle.
  - `misaligned <= 1` if `target[1:0] != 0`.
  - Redirect overrides both `stall` and `halt`.
- On adv in RUN with no redirect:
  - `stall=1`: pc holds, no kills.
  - Otherwise `pc <= pc + 4`, with XLEN-bit wrap (32'hFFFF_FFFC → 0).
- FSM states RUN, DRAIN, HALTED:
  - RUN → DRAIN on `adv && halt && !redirect && !stall`. That cycle: `kill_ifid=1`, pc holds, counter loads DRAIN_SLOTS.
  - DRAIN: `fetch_valid=0`, pc frozen, `kill_ifid=1` on every adv. `branch_sel`, `jump`, `halt` and `stall` are ignored. Each adv decrements the counter; the adv at which counter==1 moves to HALTED.
  - HALTED: `halted=1`, `adv=0`, `mem_sel=0`, all kills 0. Only reset exits.
- `misaligned` clears only on reset.

## Timing
- Reset values: `pc=RESET_PC`, `ph=0`, state RUN, counter 0. Outputs: `mem_sel=1`, `fetch_valid=1`, `adv=0`, `kill_ifid=0`, `kill_idex=0`, `misaligned=0`, `halted=0`.
- Reset asserted mid-operation (including DRAIN/HALTED) returns to these values immediately, independent of `clk`.
- First fetch is in the first cycle after `rst_n` rises. The first adv is one cycle later.
- One instruction enters per 2 cycles. PC updates at the rising edge ending the adv cycle.
- Redirect latency: branch resolved in EX on adv cycle N. Target fetched at cycle N+1 (fetch slot). Exactly 2 younger instructions are killed.
- Kill outputs are combinational from the inputs and state, and are valid only while `adv=1`.
- Inputs are sampled only in adv cycles. Values in fetch-slot cycles have no effect.
- `halted` rises after the edge ending the DRAIN_SLOTS-th adv following halt entry.

## Test plan
- Reset/sequential: release `rst_n` and run 8 cycles with no events → `pc` = 0, 0, 4, 4, 8, 8, 12, 12. `mem_sel` alternates 1,0. `adv` high on odd cycles.
- Branch taken: `branch_sel=1`, `branch_target=0x40` at the adv where pc=0x8 → `kill_ifid=kill_idex=1` that cycle, next `pc=0x40`, then 0x44. With `branch_sel=0` → pc goes to 0xC and no kills.
- Priority and misalignment:
  - `jump=1`, `jump_target=0x102`, `branch_sel=1`, `branch_target=0x200`, `stall=1` → `pc=0x100`, `misaligned=1`.
  - A later aligned redirect leaves `misaligned=1`.
- Stall: `stall=1` on 2 consecutive advs at pc=0x10 → pc stays 0x10 with no kills, then advances to 0x14.
- Halt drain:
  - `halt=1` on an adv at pc=0x20 → `kill_ifid=1`, then 3 further advs with `fetch_valid=0` and `kill_ifid=1`, then `halted=1`, `adv=0`, pc=0x20.
  - `branch_sel=1` pulsed during DRAIN is ignored.
  - Wrap-around: pc at 32'hFFFF_FFFC advances to 0.
- Async reset in HALTED (mid-cycle `rst_n=0`) → all outputs return to their reset values before the next clock edge.
